// File: rtl/patch_fetch_pkg.sv
// Shared types and CWBP mapping-entry format for the patch fetch sequencer.
// The entry word is split into a way field (top bits) and a row address (remaining bits).
package patch_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CHECK,
        S_ISSUE,
        S_NEXT,
        S_DONE
    } pfs_state_t;

    localparam int CWBP_DATA_WIDTH = 32;
    localparam int CWBP_WAY_WIDTH  = 4;
    localparam int BYTES_PER_ENTRY = CWBP_DATA_WIDTH / 8;

    function automatic logic [CWBP_WAY_WIDTH-1:0] cwbp_way(input logic [CWBP_DATA_WIDTH-1:0] d);
        return d[CWBP_DATA_WIDTH-1 -: CWBP_WAY_WIDTH];
    endfunction

    function automatic logic [CWBP_DATA_WIDTH-CWBP_WAY_WIDTH-1:0] cwbp_row(input logic [CWBP_DATA_WIDTH-1:0] d);
        return d[CWBP_DATA_WIDTH-CWBP_WAY_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/cwbp_field_decode.sv
// Pure combinational split of a CWBP mapping entry into way and row address.
module cwbp_field_decode
    import patch_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WAY_WIDTH  = 4
) (
    input  logic [DATA_WIDTH-1:0]           data,
    output logic [WAY_WIDTH-1:0]            way,
    output logic [DATA_WIDTH-WAY_WIDTH-1:0] row
);

    generate
        if (DATA_WIDTH == CWBP_DATA_WIDTH && WAY_WIDTH == CWBP_WAY_WIDTH) begin : g_std
            assign way = cwbp_way(data);
            assign row = cwbp_row(data);
        end else begin : g_gen
            assign way = data[DATA_WIDTH-1 -: WAY_WIDTH];
            assign row = data[DATA_WIDTH-WAY_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: rtl/patch_fetch_sequencer.sv
// Fetches a run of mapping entries, gates each on the selected NFC being idle and hands it to the AXI front-end.
// Optional NFC busy watchdog: define PATCH_FETCH_BUSY_TIMEOUT_EN.
module patch_fetch_sequencer
    import patch_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    DATA_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR        = 32'h4580_0000,
    parameter int                    WAY_WIDTH         = 4,
    parameter int                    NUM_CHANNELS      = 8,
    parameter int                    NUM_PATCHES       = 2,
    parameter int                    ENTRIES_PER_PATCH = 4,
    parameter int                    RD_LATENCY        = 1,
    parameter int                    TIMEOUT_CYCLES    = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(NUM_CHANNELS)-1:0]        channel_sel,
    input  logic [NUM_CHANNELS-1:0]                nfc_busy,
    output logic                                   ram_en,
    output logic [ADDR_WIDTH-1:0]                  ram_addr,
    input  logic [DATA_WIDTH-1:0]                  ram_rd_data,
    output logic                                   req_valid,
    input  logic                                   req_ready,
    output logic [WAY_WIDTH-1:0]                   req_way,
    output logic [DATA_WIDTH-WAY_WIDTH-1:0]        req_row,
    output logic                                   req_last,
    output logic                                   patch_done,
    output logic                                   all_done,
    output logic [$clog2(NUM_PATCHES+1)-1:0]       patch_count,
    output logic                                   busy,
    output logic                                   err
);

    localparam int CH_W = $clog2(NUM_CHANNELS);
    localparam int PC_W = $clog2(NUM_PATCHES + 1);
    localparam int EW   = (ENTRIES_PER_PATCH > 1) ? $clog2(ENTRIES_PER_PATCH) : 1;
    localparam int STEP = (DATA_WIDTH == CWBP_DATA_WIDTH) ? BYTES_PER_ENTRY : DATA_WIDTH / 8;

    // Handshake: a request is transferred on any cycle where req_valid and req_ready are both high;
    // once raised, req_valid and the payload hold until that cycle.

    pfs_state_t                             state;
    logic [CH_W-1:0]                        ch_q;
    logic [EW-1:0]                          entry_idx;
    logic [2:0]                             wait_cnt;
    logic [WAY_WIDTH-1:0]                   dec_way;
    logic [DATA_WIDTH-WAY_WIDTH-1:0]        dec_row;

    cwbp_field_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .WAY_WIDTH  (WAY_WIDTH)
    ) u_decode (
        .data (ram_rd_data),
        .way  (dec_way),
        .row  (dec_row)
    );

`ifdef PATCH_FETCH_BUSY_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    // No watchdog: err stays low (the compare is constant false for any legal limit).
    assign err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ch_q        <= '0;
            entry_idx   <= '0;
            wait_cnt    <= '0;
            ram_en      <= 1'b0;
            ram_addr    <= START_ADDR;
            req_valid   <= 1'b0;
            req_way     <= '0;
            req_row     <= '0;
            req_last    <= 1'b0;
            patch_done  <= 1'b0;
            all_done    <= 1'b0;
            patch_count <= '0;
            busy        <= 1'b0;
`ifdef PATCH_FETCH_BUSY_TIMEOUT_EN
            wd_cnt      <= '0;
            err         <= 1'b0;
`endif
        end else begin
            ram_en     <= 1'b0;
            patch_done <= 1'b0;
`ifdef PATCH_FETCH_BUSY_TIMEOUT_EN
            err        <= 1'b0;
`endif
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        all_done    <= 1'b0;
                        patch_count <= '0;
                        entry_idx   <= '0;
                        ram_addr    <= START_ADDR;
                        ch_q        <= channel_sel;
                        busy        <= 1'b1;
                        ram_en      <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid in the RD_LATENCY-th cycle after the enable cycle.
                    if (wait_cnt == 3'(RD_LATENCY - 1)) begin
                        req_way  <= dec_way;
                        req_row  <= dec_row;
                        req_last <= (entry_idx == EW'(ENTRIES_PER_PATCH - 1));
`ifdef PATCH_FETCH_BUSY_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                        state    <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (!nfc_busy[ch_q]) begin
                        req_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
`ifdef PATCH_FETCH_BUSY_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        err   <= 1'b1;
                        state <= S_NEXT;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_ISSUE: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    ram_addr <= ram_addr + ADDR_WIDTH'(STEP);
                    if (entry_idx != EW'(ENTRIES_PER_PATCH - 1)) begin
                        entry_idx <= entry_idx + EW'(1);
                        ram_en    <= 1'b1;
                        state     <= S_FETCH;
                    end else begin
                        entry_idx  <= '0;
                        patch_done <= 1'b1;
                        if (patch_count != PC_W'(NUM_PATCHES))
                            patch_count <= patch_count + PC_W'(1);
                        if (patch_count == PC_W'(NUM_PATCHES - 1)) begin
                            all_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            ram_en <= 1'b1;
                            state  <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
